kd_tree_node_loader: RTL and testbench

- Sequences configuration of the KD-tree internal-node array: takes a stream of node records (split dimension + median), writes each into the addressed node over a shared write bus with one-hot write enables, then reads every node back and sanity-checks it.
- Sits between the host/config receiver FIFO and the tree of internal nodes.
- Tree search must not start until `done` is asserted.

---
 rtl/kd_tree_node_loader.sv | 184 ++++++++++++++++++
 tb/tb_kd_tree_node_loader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kd_tree_node_loader.sv
// kd_tree_node_loader
//   Loads the KD-tree internal-node array from a stream of node records and
//   then reads every node back to confirm it holds a usable record. Tree
//   search must wait for `done`.
//
// Ports
//   clk, rst          rising-edge clock; asynchronous active-high reset
//   start             one-cycle pulse, begins a load from IDLE, DONE or ERR
//   abort             synchronous return to IDLE from any state
//   in_valid/in_ready record handshake; in_data = {median[10:0], 8'bx, idx[2:0]}
//   node_wen          one-hot write enable, bit k writes node k
//   node_wdata        write data shared by every node
//   node_rdata        flattened readback, node k at [k*22 +: 22]
//   busy/done/error   status levels (LOAD..VERIFY / DONE / ERR)
//   err_addr          node address of the first failure
//   loaded_count      records accepted in the current load
module kd_tree_node_loader #(
  parameter int NUM_NODES     = 31,
  parameter int ADDR_WIDTH    = 6,
  parameter int STORAGE_WIDTH = 22,
  parameter int NUM_DIMS      = 5
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               abort,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [STORAGE_WIDTH-1:0]           in_data,
  output logic [NUM_NODES-1:0]               node_wen,
  output logic [STORAGE_WIDTH-1:0]           node_wdata,
  input  logic [NUM_NODES*STORAGE_WIDTH-1:0] node_rdata,
  output logic                               busy,
  output logic                               done,
  output logic                               error,
  output logic [ADDR_WIDTH-1:0]              err_addr,
  output logic [ADDR_WIDTH:0]                loaded_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_DRAIN  = 3'd2,
    S_VERIFY = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_NODES - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1'b1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1'b1);
  localparam logic [NUM_NODES-1:0]  WEN_ONE   = NUM_NODES'(1'b1);

  // A split dimension is usable only if it names one of the tree's dimensions.
  function automatic logic idx_ok(input logic [2:0] idx);
    return (int'(idx) < NUM_DIMS);
  endfunction

  // A stored node must carry a usable dimension and a zero padding field.
  function automatic logic node_ok(input logic [10:0] low);
    return idx_ok(low[2:0]) && (low[10:3] == 8'd0);
  endfunction

  state_e                    state_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [ADDR_WIDTH:0]       loaded_count_q;
  logic [NUM_NODES-1:0]      node_wen_q;
  logic [STORAGE_WIDTH-1:0]  node_wdata_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      error_q;
  logic [ADDR_WIDTH-1:0]     err_addr_q;

  logic                      accept_d;
  logic [NUM_NODES-1:0]      wen_onehot_d;
  logic [STORAGE_WIDTH-1:0]  scan_rec_d;
  logic                      unused_median_s;

  // Abort masks the handshake so a beat offered alongside abort is never taken.
  assign in_ready     = (state_q == S_LOAD) && !abort;
  assign accept_d     = in_valid && in_ready;
  assign wen_onehot_d = WEN_ONE << addr_q;

  // Select the node currently being scanned; addr_q doubles as the scan index.
  always_comb begin
    scan_rec_d = '0;
    for (int k = 0; k < NUM_NODES; k++) begin
      scan_rec_d = scan_rec_d |
                   ((addr_q == ADDR_WIDTH'(k)) ? node_rdata[k*STORAGE_WIDTH +: STORAGE_WIDTH]
                                               : {STORAGE_WIDTH{1'b0}});
    end
  end

  // The median travels through untouched and is not part of the readback check.
  assign unused_median_s = ^scan_rec_d[STORAGE_WIDTH-1:11];

  // Load/verify sequencer with all status outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      loaded_count_q <= '0;
      node_wen_q     <= '0;
      node_wdata_q   <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      err_addr_q     <= '0;
    end else if (abort) begin
      // loaded_count and err_addr are kept for post-mortem inspection.
      state_q    <= S_IDLE;
      node_wen_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      node_wen_q <= '0;
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_q        <= S_LOAD;
            addr_q         <= '0;
            loaded_count_q <= '0;
            busy_q         <= 1'b1;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            err_addr_q     <= '0;
          end
        end
        S_LOAD: begin
          if (accept_d) begin
            loaded_count_q <= loaded_count_q + CNT_ONE;
            if (!idx_ok(in_data[2:0])) begin
              // Bad beat is consumed but never written.
              err_addr_q <= addr_q;
              error_q    <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= S_ERR;
            end else begin
              node_wen_q   <= wen_onehot_d;
              node_wdata_q <= in_data;
              addr_q       <= addr_q + ADDR_ONE;
              if (addr_q == LAST_ADDR) begin
                state_q <= S_DRAIN;
              end
            end
          end
        end
        S_DRAIN: begin
          // One idle cycle so the final write lands before it is read back.
          addr_q  <= '0;
          state_q <= S_VERIFY;
        end
        S_VERIFY: begin
          if (!node_ok(scan_rec_d[10:0])) begin
            err_addr_q <= addr_q;
            error_q    <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= S_ERR;
          end else if (addr_q == LAST_ADDR) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            addr_q <= addr_q + ADDR_ONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign node_wen     = node_wen_q;
  assign node_wdata   = node_wdata_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign err_addr     = err_addr_q;
  assign loaded_count = loaded_count_q;

endmodule

// File: tb/tb_kd_tree_node_loader.sv
// tb_kd_tree_node_loader
//   Self-checking bench for kd_tree_node_loader. Holds a model of the node
//   array (with a readback corruption hook), a table of load scenarios with
//   their expected outcomes, and hand-written abort/reset sequences.
module tb_kd_tree_node_loader;

  localparam int NN = 31;
  localparam int AW = 6;
  localparam int SW = 22;
  localparam int ND = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic              in_valid;
  logic              in_ready;
  logic [SW-1:0]     in_data;
  logic [NN-1:0]     node_wen;
  logic [SW-1:0]     node_wdata;
  logic [NN*SW-1:0]  node_rdata;
  logic              busy;
  logic              done;
  logic              error;
  logic [AW-1:0]     err_addr;
  logic [AW:0]       loaded_count;

  int tests = 0;
  int fails = 0;

  logic          mem_clr;
  logic [SW-1:0] mem [NN];
  int            corrupt_node;
  int            corrupt_kind;
  logic [SW-1:0] exp_wdata;

  typedef struct {
    int det;
    int gap;
    int bad_at;
    int cnode;
    int ckind;
    int start_at;
    bit exp_done;
    int exp_eaddr;
    int exp_count;
  } vec_t;

  vec_t vt [11];

  kd_tree_node_loader #(
    .NUM_NODES(NN), .ADDR_WIDTH(AW), .STORAGE_WIDTH(SW), .NUM_DIMS(ND)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .node_wen(node_wen), .node_wdata(node_wdata), .node_rdata(node_rdata),
    .busy(busy), .done(done), .error(error), .err_addr(err_addr),
    .loaded_count(loaded_count)
  );

  always #5 clk = ~clk;

  // Node array: each node keeps only idx and median; unwritten nodes read idx 3'b111.
  always @(posedge clk) begin
    for (int k = 0; k < NN; k++) begin
      if (mem_clr) mem[k] <= {11'd0, 8'd0, 3'b111};
      else if (node_wen[k]) mem[k] <= {node_wdata[21:11], 8'd0, node_wdata[2:0]};
    end
  end

  // Readback with an optional fault on one node (1: bad idx, 2: nonzero padding).
  always_comb begin
    node_rdata = '0;
    for (int k = 0; k < NN; k++) begin
      node_rdata[k*SW +: SW] = mem[k];
      if (k == corrupt_node && corrupt_kind == 1) node_rdata[k*SW +: 3] = 3'b111;
      if (k == corrupt_node && corrupt_kind == 2) node_rdata[k*SW+3 +: 8] = 8'h5A;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string p);
    check({p, "_in_ready"}, in_ready, 0);
    check({p, "_node_wen"}, node_wen, 0);
    check({p, "_node_wdata"}, node_wdata, 0);
    check({p, "_busy"}, busy, 0);
    check({p, "_done"}, done, 0);
    check({p, "_error"}, error, 0);
    check({p, "_err_addr"}, err_addr, 0);
    check({p, "_loaded_count"}, loaded_count, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_done", done, 0);
    check("start_error", error, 0);
    check("start_count", loaded_count, 0);
    check("start_err_addr", err_addr, 0);
    check("start_wen", node_wen, 0);
  endtask

  // Offer records until n are accepted; record k always targets node k.
  task automatic feed(input int n, input int det, input int gap, input int bad_at,
                      input int start_at, output bit hit_err);
    int k;
    int cyc;
    bit v;
    logic [SW-1:0] rec;
    k = 0;
    cyc = 0;
    hit_err = 1'b0;
    while (k < n && cyc < 400) begin
      v = ($urandom_range(0, 99) >= gap);
      if (det != 0) rec = {11'(k * 3 - 40), 8'd0, 3'(k % ND)};
      else rec = {11'($urandom), 8'($urandom), 3'($urandom_range(0, ND - 1))};
      if (k == bad_at) rec[2:0] = 3'($urandom_range(ND, 7));
      in_valid = v;
      in_data  = rec;
      start    = (cyc == start_at);
      #1;
      check("load_in_ready", in_ready, 1);
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
      if (v) begin
        if (k == bad_at) begin
          check("bad_no_wen", node_wen, 0);
          check("bad_error", error, 1);
          check("bad_err_addr", err_addr, k);
          check("bad_in_ready", in_ready, 0);
          check("bad_busy", busy, 0);
          hit_err = 1'b1;
          return;
        end
        check("wen_onehot", node_wen, 64'd1 << k);
        check("wdata", node_wdata, rec);
        exp_wdata = rec;
        k++;
        check("loaded_count", loaded_count, k);
      end else begin
        check("gap_no_wen", node_wen, 0);
        check("wdata_hold", node_wdata, exp_wdata);
        check("gap_count", loaded_count, k);
      end
      cyc++;
    end
    if (k < n) check("feed_timeout", k, n);
  endtask

  // Count edges from the last accepted beat until done or error.
  task automatic wait_end(input int exp_edges);
    int c;
    c = 0;
    while (!(done || error) && c < 200) begin
      tick();
      c++;
      if (!(done || error)) begin
        check("verify_wen_idle", node_wen, 0);
        check("verify_in_ready", in_ready, 0);
        check("verify_busy", busy, 1);
      end
    end
    check("end_latency", c, exp_edges);
  endtask

  task automatic full_load(input int det, input int gap);
    bit hit;
    do_start();
    feed(NN, det, gap, -1, -1, hit);
    check("full_no_err", hit, 0);
    check("drain_busy", busy, 1);
    check("drain_in_ready", in_ready, 0);
    wait_end(NN + 1);
    check("full_done", done, 1);
    check("full_error", error, 0);
    check("full_count", loaded_count, NN);
  endtask

  initial begin
    bit hit;
    //         det gap bad cnode ck st  done eaddr cnt
    vt[0]  = '{1,  0,  -1, -1,   0, -1, 1'b1, 0,   31};
    vt[1]  = '{0,  40, -1, -1,   0, -1, 1'b1, 0,   31};
    vt[2]  = '{0,  0,  7,  -1,   0, -1, 1'b0, 7,   -1};
    vt[3]  = '{0,  0,  -1, 12,   1, -1, 1'b0, 12,  31};
    vt[4]  = '{0,  0,  -1, -1,   0, 3,  1'b1, 0,   31};
    vt[5]  = '{0,  20, -1, 20,   2, -1, 1'b0, 20,  31};
    vt[6]  = '{0,  0,  0,  -1,   0, -1, 1'b0, 0,   -1};
    vt[7]  = '{0,  30, 30, -1,   0, -1, 1'b0, 30,  -1};
    vt[8]  = '{0,  0,  -1, 30,   1, -1, 1'b0, 30,  31};
    vt[9]  = '{0,  10, -1, 0,    1, -1, 1'b0, 0,   31};
    vt[10] = '{0,  50, -1, -1,   0, 10, 1'b1, 0,   31};

    rst = 1'b1; mem_clr = 1'b1; start = 1'b0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0; corrupt_node = -1; corrupt_kind = 0;
    exp_wdata = '0;
    repeat (2) tick();
    mem_clr = 1'b0;
    check_zero("reset");
    rst = 1'b0;
    tick();
    check_zero("idle");

    for (int i = 0; i < 11; i++) begin
      corrupt_node = vt[i].cnode;
      corrupt_kind = vt[i].ckind;
      do_start();
      feed(NN, vt[i].det, vt[i].gap, vt[i].bad_at, vt[i].start_at, hit);
      if (!hit) begin
        check("drain_busy", busy, 1);
        check("drain_in_ready", in_ready, 0);
        wait_end(vt[i].exp_done ? NN + 1 : vt[i].exp_eaddr + 2);
      end
      check("final_done", done, vt[i].exp_done);
      check("final_error", error, !vt[i].exp_done);
      if (!vt[i].exp_done) check("final_err_addr", err_addr, vt[i].exp_eaddr);
      if (vt[i].exp_count >= 0) check("final_count", loaded_count, vt[i].exp_count);
      check("final_busy", busy, 0);
      corrupt_node = -1;
    end

    // Abort after ten accepts while a beat is offered.
    do_start();
    feed(10, 0, 0, -1, -1, hit);
    in_valid = 1'b1;
    in_data  = 22'h3FFFF0;
    abort    = 1'b1;
    #1;
    check("abort_in_ready", in_ready, 0);
    check("abort_wen_still", node_wen, 64'd1 << 9);
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    check("abort_wen", node_wen, 0);
    check("abort_busy", busy, 0);
    check("abort_count", loaded_count, 10);
    check("abort_done", done, 0);
    tick();
    check("abort_idle_wen", node_wen, 0);
    check("abort_idle_ready", in_ready, 0);
    full_load(0, 25);

    // Abort from DONE clears done but keeps the count.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_done_clr", done, 0);
    check("abort_done_busy", busy, 0);
    check("abort_done_count", loaded_count, NN);

    // Reset asserted mid-cycle after five accepts takes effect without a clock edge.
    do_start();
    feed(5, 0, 0, -1, -1, hit);
    in_valid = 1'b1;
    in_data  = 22'h000001;
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    exp_wdata = '0;
    tick();
    check_zero("after_rst");
    full_load(1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
